// File: rtl/vc_switch_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_switch_arbiter_pkg : flit encodings, defaults and FSM state type
// Revision: 1.0
// ---------------------------------------------------------------------------
package vc_switch_arbiter_pkg;

  localparam int FLIT_DATA_W     = 16;
  localparam int NUM_VC_DEF      = 4;
  localparam int VC_CREDIT_DEPTH = 8;
  localparam int FLIT_TYPE_MSB   = FLIT_DATA_W - 1;

  localparam logic [1:0] FLIT_TYPE_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TYPE_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // HEAD and SINGLE share bit 0; TAIL and SINGLE share bit 1.
  function automatic logic is_head_type(input logic [1:0] t);
    return t[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vc_switch_arbiter_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin select, search starts after ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_VC  = 4,
  parameter int VC_ID_W = 2
) (
  input  logic [NUM_VC-1:0]  req,
  input  logic [VC_ID_W-1:0] ptr,
  output logic [NUM_VC-1:0]  grant,
  output logic [VC_ID_W-1:0] grant_idx,
  output logic               grant_valid
);

  logic [VC_ID_W-1:0] cand;

  // k == NUM_VC wraps back to ptr itself, so the last holder is lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_VC; k++) begin
      cand = ptr + VC_ID_W'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant = grant_valid ? (NUM_VC'(1) << grant_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/vc_switch_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_switch_arbiter : wormhole VC-to-link mux with per-VC downstream credits
// Revision: 1.0
// ---------------------------------------------------------------------------
module vc_switch_arbiter
  import vc_switch_arbiter_pkg::*;
#(
  parameter int NUM_VC       = NUM_VC_DEF,
  parameter int VC_ID_W      = 2,
  parameter int CREDIT_DEPTH = VC_CREDIT_DEPTH,
  parameter int CREDIT_W     = 4,
  parameter int DATA_WIDTH   = FLIT_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_VC*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_VC-1:0]            in_valid,
  output logic [NUM_VC-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [VC_ID_W-1:0]           out_vc_id,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic [NUM_VC-1:0]            credit_in,
  output logic                         busy,
  output logic                         err
);

  arb_state_e            state_q, state_d;
  logic [VC_ID_W-1:0]    lock_vc_q, lock_vc_d;
  logic [VC_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CREDIT_W-1:0]   credit_q [NUM_VC];
  logic [CREDIT_W-1:0]   credit_d [NUM_VC];
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [VC_ID_W-1:0]    out_vc_id_q, out_vc_id_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_q, err_d;

  logic                  slot_free;
  logic [1:0]            ftype [NUM_VC];
  logic [NUM_VC-1:0]     elig;
  logic [NUM_VC-1:0]     head_req;
  logic [NUM_VC-1:0]     bad_idle;
  logic [NUM_VC-1:0]     arb_grant;
  logic [VC_ID_W-1:0]    arb_idx;
  logic                  arb_valid;
  logic [VC_ID_W-1:0]    sel_vc;
  logic                  fsm_err;
  logic                  credit_err;

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      ftype[i]    = in_data[i*DATA_WIDTH + DATA_WIDTH - 1 -: 2];
      elig[i]     = in_valid[i] && (credit_q[i] != '0) && slot_free;
      head_req[i] = elig[i] && is_head_type(ftype[i]);
      bad_idle[i] = in_valid[i] && !is_head_type(ftype[i]);
    end
  end

  rr_arbiter #(
    .NUM_VC  (NUM_VC),
    .VC_ID_W (VC_ID_W)
  ) u_rr_arbiter (
    .req         (head_req),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    in_ready  = '0;
    sel_vc    = lock_vc_q;
    fsm_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = arb_grant;
        sel_vc   = arb_idx;
        fsm_err  = |bad_idle;
        if (arb_valid) begin
          rr_ptr_d = arb_idx;
          if (ftype[arb_idx] == FLIT_TYPE_HEAD) begin
            state_d   = ST_LOCKED;
            lock_vc_d = arb_idx;
          end
        end
      end
      ST_LOCKED: begin
        in_ready[lock_vc_q] = elig[lock_vc_q];
        // A stray HEAD/SINGLE mid-packet is forwarded and closes the packet.
        if (elig[lock_vc_q] && ftype[lock_vc_q] != FLIT_TYPE_BODY) begin
          state_d = ST_IDLE;
          fsm_err = is_head_type(ftype[lock_vc_q]);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_vc_id_d = out_vc_id_q;
    if (|in_ready) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[sel_vc*DATA_WIDTH +: DATA_WIDTH];
      out_vc_id_d = sel_vc;
    end
  end

  // Credits debit on acceptance into the output register, not at link handshake.
  always_comb begin
    credit_err = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      credit_d[i] = credit_q[i];
      case ({credit_in[i], in_ready[i]})
        2'b10: begin
          if (credit_q[i] == CREDIT_W'(CREDIT_DEPTH)) credit_err = 1'b1;
          else credit_d[i] = credit_q[i] + 1'b1;
        end
        2'b01:   credit_d[i] = credit_q[i] - 1'b1;
        default: credit_d[i] = credit_q[i];
      endcase
    end
    err_d = err_q || fsm_err || credit_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_vc_q   <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_vc_id_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) credit_q[i] <= CREDIT_W'(CREDIT_DEPTH);
    end else begin
      state_q     <= state_d;
      lock_vc_q   <= lock_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_vc_id_q <= out_vc_id_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_VC; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign out_data  = out_data_q;
  assign out_vc_id = out_vc_id_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_LOCKED);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/vc_switch_arbiter.md
Name: vc_switch_arbiter

Overview:
- Output stage directly downstream of the per-VC buffers: consumes flits from NUM_VC virtual channels and multiplexes them onto one physical link.
- Wormhole switching: once a VC's head flit wins round-robin arbitration, the link stays locked to that VC until its tail flit is sent.
- Per-VC credit counters track free slots in the downstream VC buffers; a VC with zero credits cannot send.
- Output is registered, with one-cycle latency from acceptance to out_valid.

Parameters:
- NUM_VC, 4: number of virtual channels (power of two).
- VC_ID_W, 2: log2(NUM_VC); width of out_vc_id.
- CREDIT_DEPTH, 8: downstream buffer depth per VC; reset value of every credit counter.
- CREDIT_W, 4: credit counter width; must hold CREDIT_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_VC*DATA_WIDTH  flit per VC; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_VC  flit present per VC.
- in_ready  out  NUM_VC  flit accepted per VC.
- out_data  out  DATA_WIDTH  registered link flit.
- out_vc_id  out  VC_ID_W  VC tag of out_data.
- out_valid  out  1  link flit valid.
- out_ready  in  1  link accepts flit.
- credit_in  in  NUM_VC  one-cycle pulse per freed downstream slot, per VC.
- busy  out  1  high in LOCKED state.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Flit type field: in_data[DATA_WIDTH-1 -: 2]. 01 = HEAD, 00 = BODY, 10 = TAIL, 11 = SINGLE (head and tail).
- Reset values: out_valid 0, out_data 0, out_vc_id 0, in_ready 0, busy 0, err 0, state IDLE, rr pointer 0, all credits CREDIT_DEPTH. Reset mid-packet discards the lock and any held output flit.
- Output slot free: slot_free = !out_valid || out_ready.
- Eligibility: VC i is eligible when in_valid[i] && credit[i] != 0 && slot_free.
- IDLE state:
  - Round-robin select among eligible VCs whose flit is HEAD or SINGLE. Search starts at rr_ptr+1 and wraps modulo NUM_VC.
  - Winner g gets in_ready[g] = 1 in the same cycle (combinational grant).
  - HEAD: go to LOCKED(g). SINGLE: stay in IDLE.
  - In both cases rr_ptr <= g.
- LOCKED(g) state:
  - Only VC g may be granted; in_ready[g] = in_valid[g] && credit[g] != 0 && slot_free.
  - Other VCs are stalled even if eligible.
  - A TAIL transfer returns the FSM to IDLE in the next cycle.
  - credit[g] == 0 stalls the FSM in LOCKED; no preemption.
- Protocol errors (each sets err, sticky until reset):
  - In IDLE, a valid flit of type BODY or TAIL at the head of a VC is never granted.
  - In LOCKED, a HEAD or SINGLE flit on g is forwarded, closed as if TAIL (back to IDLE).
- Transfer: in_valid[g] && in_ready[g]. Next cycle out_data = that flit, out_vc_id = g, out_valid = 1.
- Link hold: out_valid && !out_ready holds out_data, out_vc_id and out_valid stable. At most one flit in flight in the stage, no skid buffer.
- Credits:
  - Transfer on VC i: credit[i] - 1.
  - credit_in[i]: credit[i] + 1.
  - Both in the same cycle: credit unchanged.
  - Increment at CREDIT_DEPTH saturates and sets err.
  - Credit decrements at acceptance into the output register, not at link handshake.
- Throughput: one flit per cycle when out_ready is held high and credits are available.

Decomposition:
- Shared in npu_definitions.vh: DATA_WIDTH, FLIT_TYPE_HEAD/BODY/TAIL/SINGLE constants, FLIT_TYPE_MSB, NUM_VC default, VC_CREDIT_DEPTH.
- Sub-module rr_arbiter: NUM_VC request vector plus pointer in, one-hot grant plus encoded index out, purely combinational. Pointer register stays in the parent.
- Credit counters and FSM stay inline.

Test Plan:
- Reset, then VC1 sends a SINGLE flit with out_ready=1 -> in_ready[1] pulses in cycle 0; cycle 1: out_valid=1, out_vc_id=1; credit[1]=7.
- VC0 and VC2 each present a 3-flit packet (HEAD, BODY, TAIL) simultaneously, rr_ptr=0 -> VC2 wins; link shows VC2 flits x3, then VC0 flits x3, never interleaved; busy high during each packet.
- VC3 sends 8 SINGLE flits with no credit_in -> 8 accepted; 9th stalls with in_ready[3]=0 until one credit_in[3] pulse, then it is accepted the cycle after.
- out_ready=0 for 4 cycles with out_valid=1 -> out_data and out_vc_id stable, all in_ready=0; out_ready=1 -> next flit accepted the same cycle.
- credit_in[0] pulse coincident with a VC0 transfer -> credit[0] unchanged; credit_in[0] while credit[0]=8 -> err=1, credit stays 8.
- Assert rst mid-packet while LOCKED on VC1 -> next cycle: out_valid=0, busy=0, credits=8, err=0; a new HEAD on VC2 is granted normally.
